// File: rtl/decode38_defs.sv
// Shared definitions for the registered 3-to-8 decoder controller:
// state encoding and field positions inside the {indicate, code} word.
package decode38_defs;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOW  = 2'd1,
        S_CHASE = 2'd2
    } state_t;

    localparam int unsigned IND_BIT  = 3;
    localparam int unsigned CODE_MSB = 2;

endpackage

// File: rtl/decode38.sv
// Combinational 3-to-8 decoder with enable; mirror of the 8-3 priority encoder.
module decode38 (
    input  logic       en,
    input  logic [2:0] x,
    output logic [7:0] y
);

    always_comb begin
        y = '0;
        if (en) y = 8'd1 << x;
    end

endmodule

// File: rtl/decode38_ctrl.sv
// Registered decoder controller: latches {indicate, code} on load, displays it
// one-hot with an optional hold timeout, or walks a single LED in chase mode.
module decode38_ctrl
    import decode38_defs::*;
#(
    parameter int unsigned DIV  = 4,
    parameter int unsigned HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       mode,
    input  logic       load,
    input  logic [3:0] code_in,
    output logic [7:0] led_out,
    output logic [2:0] code_out,
    output logic       valid_out
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD == 0) ? 0 : HOLD - 1);

    state_t        state_q, state_d;
    logic [2:0]    pos_q, pos_d;
    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [2:0]    code_d;
    logic [7:0]    led_d;
    logic          valid_load;

    assign valid_load = load && code_in[IND_BIT];

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        div_d   = div_q;
        hold_d  = hold_q;
        code_d  = code_out;
        if (!en) begin
            state_d = S_IDLE;
            pos_d   = '0;
            div_d   = '0;
            hold_d  = '0;
            code_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mode) begin
                        state_d = S_CHASE;
                        pos_d   = '0;
                        div_d   = '0;
                        code_d  = '0;
                    end else if (valid_load) begin
                        state_d = S_SHOW;
                        code_d  = code_in[CODE_MSB:0];
                        hold_d  = '0;
                    end
                end
                S_SHOW: begin
                    if (mode) begin
                        state_d = S_CHASE;
                        pos_d   = '0;
                        div_d   = '0;
                        hold_d  = '0;
                        code_d  = '0;
                    end else if (valid_load) begin
                        code_d = code_in[CODE_MSB:0];
                        hold_d = '0;
                    end else if (HOLD != 0) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = S_IDLE;
                            hold_d  = '0;
                            code_d  = '0;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                S_CHASE: begin
                    if (!mode) begin
                        state_d = S_IDLE;
                        pos_d   = '0;
                        div_d   = '0;
                        code_d  = '0;
                    end else if (div_q == DIV_LAST) begin
                        div_d  = '0;
                        pos_d  = pos_q + 3'd1;
                        code_d = pos_q + 3'd1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    pos_d   = '0;
                    div_d   = '0;
                    hold_d  = '0;
                    code_d  = '0;
                end
            endcase
        end
    end

    // LED value is decoded from the next-state code so the register stays one-hot.
    decode38 u_dec (
        .en (state_d != S_IDLE),
        .x  (code_d),
        .y  (led_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pos_q     <= '0;
            div_q     <= '0;
            hold_q    <= '0;
            code_out  <= '0;
            led_out   <= '0;
            valid_out <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            div_q     <= div_d;
            hold_q    <= hold_d;
            code_out  <= code_d;
            led_out   <= led_d;
            valid_out <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_decode38_ctrl.sv
// Self-checking bench for decode38_ctrl: directed test-plan steps followed by
// randomized traffic, all compared against a cycle-count behavioural model.
module tb_decode38_ctrl;

    localparam int DIV  = 4;
    localparam int HOLD = 16;

    localparam int K_OFF   = 0;
    localparam int K_SHOW  = 1;
    localparam int K_CHASE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       load = 1'b0;
    logic [3:0] code_in = '0;
    logic [7:0] led_out;
    logic [2:0] code_out;
    logic       valid_out;

    int checks = 0;
    int errors = 0;

    // Model: what is being displayed, and how long it has been displayed.
    int m_kind = K_OFF;
    int m_code = 0;
    int m_age  = 0;
    int m_t    = 0;

    decode38_ctrl #(.DIV(DIV), .HOLD(HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .load      (load),
        .code_in   (code_in),
        .led_out   (led_out),
        .code_out  (code_out),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_kind = K_OFF;
        m_code = 0;
        m_age  = 0;
        m_t    = 0;
    endtask

    task automatic model_edge(input logic e, input logic m, input logic l, input logic [3:0] c);
        if (!e) begin
            m_kind = K_OFF;
        end else if (m) begin
            if (m_kind != K_CHASE) begin
                m_kind = K_CHASE;
                m_t    = 0;
            end else begin
                m_t++;
            end
        end else if (m_kind == K_CHASE) begin
            m_kind = K_OFF;
        end else if (l && c[3]) begin
            m_kind = K_SHOW;
            m_code = int'(c[2:0]);
            m_age  = 0;
        end else if (m_kind == K_SHOW) begin
            m_age++;
            if (HOLD != 0 && m_age >= HOLD) m_kind = K_OFF;
        end
    endtask

    task automatic check_model(input string tag);
        int c;
        logic [7:0] exp_led;
        c = 0;
        if (m_kind == K_SHOW)  c = m_code;
        if (m_kind == K_CHASE) c = (m_t / DIV) % 8;
        exp_led = (m_kind == K_OFF) ? 8'h00 : 8'(1 << c);
        chk({tag, ".led"},   led_out, exp_led);
        chk({tag, ".code"},  8'(code_out), 8'(c));
        chk({tag, ".valid"}, 8'(valid_out), 8'(m_kind != K_OFF));
    endtask

    task automatic step(input logic e, input logic m, input logic l, input logic [3:0] c,
                        input string tag);
        en = e; mode = m; load = l; code_in = c;
        @(posedge clk);
        model_edge(e, m, l, c);
        #1;
        check_model(tag);
    endtask

    initial begin
        // Reset state
        #12;
        chk("reset.led", led_out, 8'h00);
        chk("reset.valid", 8'(valid_out), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Load code 5, hold exactly HOLD cycles
        step(1, 0, 1, 4'b1101, "load5");
        chk("plan.led20", led_out, 8'h20);
        for (int i = 1; i < HOLD; i++) step(1, 0, 0, 4'b0000, "hold5");
        chk("plan.still20", led_out, 8'h20);
        step(1, 0, 0, 4'b0000, "timeout5");
        chk("plan.blank", led_out, 8'h00);

        // Invalid load ignored and does not extend; valid load relatches
        step(1, 0, 1, 4'b1101, "reload5");
        for (int i = 0; i < 5; i++) step(1, 0, 0, 4'b0000, "age5");
        step(1, 0, 1, 4'b0011, "invalid");
        chk("plan.inv20", led_out, 8'h20);
        step(1, 0, 1, 4'b1000, "load0");
        chk("plan.led01", led_out, 8'h01);
        for (int i = 1; i < HOLD + 2; i++) step(1, 0, 0, 4'b0000, "hold0");

        // Chase from IDLE with load pulses ignored; full wrap
        for (int i = 0; i < 8 * DIV + 2; i++)
            step(1, 1, (i % 3) == 0, 4'b1110, "chase");

        // SHOW + mode + load in same cycle: chase wins; dropping mode blanks
        step(1, 0, 0, 4'b0000, "leave_chase");
        step(1, 0, 1, 4'b1011, "load3");
        step(1, 1, 1, 4'b1110, "mode_wins");
        chk("plan.chase01", led_out, 8'h01);
        step(1, 0, 0, 4'b0000, "mode_drop");
        chk("plan.drop00", led_out, 8'h00);

        // Drop en mid-chase at pos 3, re-enable restarts at pos 0
        for (int i = 0; i < 3 * DIV + 1; i++) step(1, 1, 0, 4'b0000, "to_pos3");
        chk("plan.pos3", led_out, 8'h08);
        step(0, 1, 0, 4'b0000, "en_drop");
        chk("plan.en00", led_out, 8'h00);
        step(1, 1, 0, 4'b0000, "en_raise");
        chk("plan.restart01", led_out, 8'h01);

        // Asynchronous reset during SHOW
        step(1, 0, 0, 4'b0000, "leave2");
        step(1, 0, 1, 4'b1110, "load6");
        step(1, 0, 0, 4'b0000, "show6");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, 4'b0000, "post_rst_chase");
        for (int i = 0; i < DIV; i++) step(1, 1, 0, 4'b0000, "post_rst_run");
        step(1, 0, 0, 4'b0000, "post_rst_idle");

        // Randomized traffic
        begin
            logic m_r;
            m_r = 1'b0;
            for (int i = 0; i < 800; i++) begin
                logic e_r, l_r;
                logic [3:0] c_r;
                if ($urandom_range(0, 19) == 0) m_r = ~m_r;
                e_r = ($urandom_range(0, 29) != 0);
                l_r = ($urandom_range(0, 9) < 2);
                c_r = 4'($urandom);
                step(e_r, m_r, l_r, c_r, "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
